// File: rtl/demux1to3_32bit_buf.sv
// rtl/demux1to3_32bit_buf.sv - 1-to-3 word demux with a buffered valid/ready FIFO per output channel
// Holds the per-channel FIFO and the top-level demux that steers each word by i_sel.

module demux1to3_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [31:0]      i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [31:0]      o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [31:0]      r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra wrap bit distinguishes full from empty when the low bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = !w_empty && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_cnt    <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_cnt   = r_cnt;
endmodule

module demux1to3_32bit_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_data,
    input  logic [1:0]       i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [31:0]      o_a_data,
    output logic             o_a_valid,
    input  logic             i_a_ready,
    output logic [31:0]      o_b_data,
    output logic             o_b_valid,
    input  logic             i_b_ready,
    output logic [31:0]      o_c_data,
    output logic             o_c_valid,
    input  logic             i_c_ready,
    output logic [CNT_W-1:0] o_cnt_a,
    output logic [CNT_W-1:0] o_cnt_b,
    output logic [CNT_W-1:0] o_cnt_c,
    output logic             o_idle
);
    logic w_push_a, w_push_b, w_push_c;
    logic w_full_a, w_full_b, w_full_c;
    logic w_empty_a, w_empty_b, w_empty_c;

    // i_valid gates every push, so an unknown i_sel while idle cannot write.
    assign w_push_a = i_valid && (i_sel == 2'b00);
    assign w_push_b = i_valid && (i_sel == 2'b01);
    assign w_push_c = i_valid && i_sel[1];

    always_comb begin
        o_ready = 1'b0;
        case (i_sel)
            2'b00:   o_ready = !w_full_a;
            2'b01:   o_ready = !w_full_b;
            default: o_ready = !w_full_c;
        endcase
    end

    demux1to3_chan_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push_a),
        .i_data  (i_data),
        .o_full  (w_full_a),
        .o_empty (w_empty_a),
        .o_data  (o_a_data),
        .o_valid (o_a_valid),
        .i_ready (i_a_ready),
        .o_cnt   (o_cnt_a)
    );

    demux1to3_chan_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push_b),
        .i_data  (i_data),
        .o_full  (w_full_b),
        .o_empty (w_empty_b),
        .o_data  (o_b_data),
        .o_valid (o_b_valid),
        .i_ready (i_b_ready),
        .o_cnt   (o_cnt_b)
    );

    demux1to3_chan_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_c (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push_c),
        .i_data  (i_data),
        .o_full  (w_full_c),
        .o_empty (w_empty_c),
        .o_data  (o_c_data),
        .o_valid (o_c_valid),
        .i_ready (i_c_ready),
        .o_cnt   (o_cnt_c)
    );

    assign o_idle = w_empty_a && w_empty_b && w_empty_c;
endmodule

// File: tb/tb_demux1to3_32bit_buf.sv
// tb/tb_demux1to3_32bit_buf.sv - scoreboard bench for demux1to3_32bit_buf
module tb_demux1to3_32bit_buf;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [31:0]      i_data;
    logic [1:0]       i_sel;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      o_a_data, o_b_data, o_c_data;
    logic             o_a_valid, o_b_valid, o_c_valid;
    logic             i_a_ready, i_b_ready, i_c_ready;
    logic [CNT_W-1:0] o_cnt_a, o_cnt_b, o_cnt_c;
    logic             o_idle;

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    int          cnt_m[3];

    demux1to3_32bit_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_data    (i_data),
        .i_sel     (i_sel),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_a_data  (o_a_data),
        .o_a_valid (o_a_valid),
        .i_a_ready (i_a_ready),
        .o_b_data  (o_b_data),
        .o_b_valid (o_b_valid),
        .i_b_ready (i_b_ready),
        .o_c_data  (o_c_data),
        .o_c_valid (o_c_valid),
        .i_c_ready (i_c_ready),
        .o_cnt_a   (o_cnt_a),
        .o_cnt_b   (o_cnt_b),
        .o_cnt_c   (o_cnt_c),
        .o_idle    (o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic [31:0] qfront(input int ch);
        case (ch)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    task automatic qpop(input int ch);
        case (ch)
            0:       void'(qa.pop_front());
            1:       void'(qb.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    task automatic qpush(input int ch, input logic [31:0] d);
        case (ch)
            0:       qa.push_back(d);
            1:       qb.push_back(d);
            default: qc.push_back(d);
        endcase
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid_a"}, {31'b0, o_a_valid}, {31'b0, qsize(0) != 0});
        check({tag, "_valid_b"}, {31'b0, o_b_valid}, {31'b0, qsize(1) != 0});
        check({tag, "_valid_c"}, {31'b0, o_c_valid}, {31'b0, qsize(2) != 0});
        if (qsize(0) != 0) check({tag, "_data_a"}, o_a_data, qfront(0));
        if (qsize(1) != 0) check({tag, "_data_b"}, o_b_data, qfront(1));
        if (qsize(2) != 0) check({tag, "_data_c"}, o_c_data, qfront(2));
        check({tag, "_cnt_a"}, {16'b0, o_cnt_a}, cnt_m[0] % 65536);
        check({tag, "_cnt_b"}, {16'b0, o_cnt_b}, cnt_m[1] % 65536);
        check({tag, "_cnt_c"}, {16'b0, o_cnt_c}, cnt_m[2] % 65536);
        check({tag, "_idle"}, {31'b0, o_idle},
              {31'b0, (qsize(0) == 0) && (qsize(1) == 0) && (qsize(2) == 0)});
    endtask

    // One cycle: drive at negedge, check just after, model the rising edge.
    task automatic step(input string tag, input logic v, input logic [1:0] sel,
                        input logic [31:0] d, input logic ra, input logic rb,
                        input logic rc, output logic acc);
        int  ch;
        logic exp_rdy;
        logic [2:0] pop;
        @(negedge clk);
        i_valid = v; i_sel = sel; i_data = d;
        i_a_ready = ra; i_b_ready = rb; i_c_ready = rc;
        #1;
        ch      = (sel == 2'b00) ? 0 : (sel == 2'b01) ? 1 : 2;
        exp_rdy = (qsize(ch) < DEPTH);
        if (v) check({tag, "_ready"}, {31'b0, o_ready}, {31'b0, exp_rdy});
        check_state(tag);
        pop[0] = (qsize(0) != 0) && ra;
        pop[1] = (qsize(1) != 0) && rb;
        pop[2] = (qsize(2) != 0) && rc;
        acc    = v && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (pop[k]) begin
                qpop(k);
                cnt_m[k]++;
            end
        end
        if (acc) qpush(ch, d);
    endtask

    task automatic send(input string tag, input logic [1:0] sel, input logic [31:0] d,
                        input logic ra, input logic rb, input logic rc);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            step(tag, 1'b1, sel, d, ra, rb, rc, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=not_accepted exp=accepted", tag);
        end
    endtask

    task automatic idle_n(input string tag, input int n, input logic ra,
                          input logic rb, input logic rc);
        logic acc;
        for (int k = 0; k < n; k++) step(tag, 1'b0, 2'bxx, 32'h0, ra, rb, rc, acc);
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); qc.delete();
        for (int k = 0; k < 3; k++) cnt_m[k] = 0;
    endtask

    initial begin
        logic acc;
        logic rc_t;
        rst_n = 1'b0; i_valid = 1'b0; i_sel = 2'b00; i_data = '0;
        i_a_ready = 1'b0; i_b_ready = 1'b0; i_c_ready = 1'b0;
        model_reset();
        #12;
        check("rst_data_a", o_a_data, 32'h0);
        check("rst_data_b", o_b_data, 32'h0);
        check("rst_data_c", o_c_data, 32'h0);
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single word to a
        step("a1", 1'b1, 2'b00, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b1, acc);
        idle_n("a1_drain", 2, 1'b1, 1'b1, 1'b1);

        // routing across b and both c encodings
        send("route_b", 2'b01, 32'hBBBB_BBBB, 1'b1, 1'b1, 1'b1);
        send("route_c", 2'b10, 32'hCCCC_CCCC, 1'b1, 1'b1, 1'b1);
        send("route_d", 2'b11, 32'hDDDD_DDDD, 1'b1, 1'b1, 1'b1);
        idle_n("route_drain", 3, 1'b1, 1'b1, 1'b1);
        check("route_cnt_b", {16'b0, o_cnt_b}, 32'd1);
        check("route_cnt_c", {16'b0, o_cnt_c}, 32'd2);

        // backpressure on a: third word refused, b still open
        step("bp1", 1'b1, 2'b00, 32'd1, 1'b0, 1'b1, 1'b1, acc);
        step("bp2", 1'b1, 2'b00, 32'd2, 1'b0, 1'b1, 1'b1, acc);
        step("bp3", 1'b1, 2'b00, 32'd3, 1'b0, 1'b1, 1'b1, acc);
        check("bp3_refused", {31'b0, acc}, 32'd0);
        step("bp_b", 1'b1, 2'b01, 32'd9, 1'b0, 1'b1, 1'b1, acc);
        check("bp_b_acc", {31'b0, acc}, 32'd1);
        // full a popping in the same cycle still refuses the push
        step("fullpop", 1'b1, 2'b00, 32'd3, 1'b1, 1'b1, 1'b1, acc);
        check("fullpop_refused", {31'b0, acc}, 32'd0);
        send("bp_retry", 2'b00, 32'd3, 1'b1, 1'b1, 1'b1);
        idle_n("bp_drain", 4, 1'b1, 1'b1, 1'b1);
        check("bp_cnt_a", {16'b0, o_cnt_a}, 32'd4);

        // pointer wrap through c with toggling consumer
        rc_t = 1'b0;
        for (int w = 0; w < 10; w++) begin
            logic acc2;
            acc2 = 1'b0;
            for (int t = 0; t < 20 && !acc2; t++) begin
                rc_t = ~rc_t;
                step("wrap", 1'b1, 2'b10, w, 1'b1, 1'b1, rc_t, acc2);
            end
            if (!acc2) check("wrap_timeout", 32'd0, 32'd1);
        end
        for (int t = 0; t < 12; t++) begin
            rc_t = ~rc_t;
            step("wrap_drain", 1'b0, 2'bxx, 32'h0, 1'b1, 1'b1, rc_t, acc);
        end
        check("wrap_cnt_c", {16'b0, o_cnt_c}, 32'd12);
        check("wrap_idle", {31'b0, o_idle}, 32'd1);

        // async reset mid-stream with words parked in b
        send("rst_b0", 2'b01, 32'h1111_0000, 1'b1, 1'b0, 1'b1);
        send("rst_b1", 2'b01, 32'h1111_0001, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid_b", {31'b0, o_b_valid}, 32'd0);
        check("arst_cnt_b", {16'b0, o_cnt_b}, 32'd0);
        check("arst_idle", {31'b0, o_idle}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 2'b01, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, acc);
        check("post_rst_acc", {31'b0, acc}, 32'd1);
        idle_n("post_drain", 2, 1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
